// File: rtl/regfile_dump_pkg.sv
// regfile_dump_pkg: shared constants for the register-file dump reader.
//   IDX_W   register index width (MIPS has 32 GPRs)
//   DATA_W  register data width
//   State encoding: IDLE=0, WAIT=1, SEND=2, CSUM=3.
//   CSUM only exists when REGDUMP_CHECKSUM_EN is defined.
package regfile_dump_pkg;

    localparam int IDX_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_CSUM = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_WAIT = S_WAIT,
        ST_SEND = S_SEND
`ifdef REGDUMP_CHECKSUM_EN
        , ST_CSUM = S_CSUM
`endif
    } state_t;

endpackage

// File: rtl/regfile_dump.sv
// regfile_dump: sweeps the register file's debug read port over
// [FIRST_REG..LAST_REG] and streams each word out on a valid/ready port.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           begin a dump (only honoured in IDLE)
//   abort           synchronous cancel back to IDLE, no done pulse
//   debug_addr      register index presented to the register file
//   debug_data      register file read data (valid one cycle after addr)
//   out_valid/ready beat handshake
//   out_addr/data   register index and value of the beat
//   out_last        final beat of the dump
//   busy            not IDLE
//   done            one-cycle pulse after the final beat is accepted
//
// Optional feature: REGDUMP_CHECKSUM_EN appends an XOR checksum beat
// (out_addr=0, out_last=1) after the last register.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [IDX_W-1:0]  debug_addr,
    input  logic [DATA_W-1:0] debug_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_REG);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_REG);

    state_t            state, state_n;
    logic [IDX_W-1:0]  cur, cur_n;
    logic [IDX_W-1:0]  debug_addr_n;
    logic              out_valid_n;
    logic [IDX_W-1:0]  out_addr_n;
    logic [DATA_W-1:0] out_data_n;
    logic              out_last_n;
    logic              done_n;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum, csum_n;
`endif

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cur        <= '0;
            debug_addr <= '0;
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
            out_last   <= 1'b0;
            done       <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            state      <= state_n;
            cur        <= cur_n;
            debug_addr <= debug_addr_n;
            out_valid  <= out_valid_n;
            out_addr   <= out_addr_n;
            out_data   <= out_data_n;
            out_last   <= out_last_n;
            done       <= done_n;
`ifdef REGDUMP_CHECKSUM_EN
            csum       <= csum_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        cur_n        = cur;
        debug_addr_n = debug_addr;
        out_valid_n  = out_valid;
        out_addr_n   = out_addr;
        out_data_n   = out_data;
        out_last_n   = out_last;
        done_n       = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
        csum_n       = csum;
`endif
        // abort wins over start and over a handshake in the same cycle
        if (abort) begin
            state_n     = ST_IDLE;
            out_valid_n = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur_n        = FIRST_IDX;
                        debug_addr_n = FIRST_IDX;
                        state_n      = ST_WAIT;
`ifdef REGDUMP_CHECKSUM_EN
                        csum_n       = '0;
`endif
                    end
                end
                // register file updates debug_data on the falling edge, so
                // it is settled by this rising edge
                ST_WAIT: begin
                    out_data_n  = debug_data;
                    out_addr_n  = cur;
                    out_valid_n = 1'b1;
                    state_n     = ST_SEND;
`ifdef REGDUMP_CHECKSUM_EN
                    out_last_n  = 1'b0;
                    csum_n      = csum ^ debug_data;
`else
                    out_last_n  = (cur == LAST_IDX);
`endif
                end
                ST_SEND: begin
                    if (out_valid && out_ready) begin
                        // compare before increment so LAST_REG=31 never wraps
                        if (cur != LAST_IDX) begin
                            cur_n        = cur + 1'b1;
                            debug_addr_n = cur + 1'b1;
                            out_valid_n  = 1'b0;
                            state_n      = ST_WAIT;
                        end else begin
`ifdef REGDUMP_CHECKSUM_EN
                            // csum already folds in the last capture; keep
                            // out_valid high and swap in the checksum beat
                            out_addr_n  = '0;
                            out_data_n  = csum;
                            out_last_n  = 1'b1;
                            state_n     = ST_CSUM;
`else
                            out_valid_n = 1'b0;
                            done_n      = 1'b1;
                            state_n     = ST_IDLE;
`endif
                        end
                    end
                end
`ifdef REGDUMP_CHECKSUM_EN
                ST_CSUM: begin
                    if (out_valid && out_ready) begin
                        out_valid_n = 1'b0;
                        done_n      = 1'b1;
                        state_n     = ST_IDLE;
                    end
                end
`endif
                default: state_n = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed bench for regfile_dump. A default instance
// (r0..r31) and a subrange instance (r8..r15) share one register file
// model that returns 0 for r0 and 0x1000_0000+i otherwise.
// Expectations adapt to REGDUMP_CHECKSUM_EN.
module tb_regfile_dump;

`ifdef REGDUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk, rst_n;
    logic        start, abort, out_ready;
    logic [4:0]  debug_addr, out_addr;
    logic [31:0] debug_data, out_data;
    logic        out_valid, out_last, busy, done;

    logic        s_start, s_abort, s_ready;
    logic [4:0]  s_debug_addr, s_out_addr;
    logic [31:0] s_debug_data, s_out_data;
    logic        s_out_valid, s_out_last, s_busy, s_done;

    int checks = 0;
    int errors = 0;

    regfile_dump u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .debug_addr(debug_addr), .debug_data(debug_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
    );

    regfile_dump #(.FIRST_REG(8), .LAST_REG(15)) u_sub (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
        .debug_addr(s_debug_addr), .debug_data(s_debug_data),
        .out_valid(s_out_valid), .out_ready(s_ready), .out_addr(s_out_addr),
        .out_data(s_out_data), .out_last(s_out_last), .busy(s_busy), .done(s_done)
    );

    function automatic logic [31:0] regval(input int i);
        return (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // register file debug port: updates on the falling edge
    always @(negedge clk) begin
        debug_data   <= regval(int'(debug_addr));
        s_debug_data <= regval(int'(s_debug_addr));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nb;
        bit seen, found, any_done;
        logic [31:0] csum_m;

        rst_n = 1'b0; start = 0; abort = 0; out_ready = 0;
        s_start = 0; s_abort = 0; s_ready = 0;
        #12;
        chk("rst_dbg_addr", 32'(debug_addr), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_out_addr", 32'(out_addr), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        step();
        rst_n = 1'b1;
        step();

        // ---- full dump, out_ready held high ----
        out_ready = 1;
        start = 1; step(); start = 0;               // edge 0
        chk("full_dbg_first", 32'(debug_addr), 0);
        nb = 0; seen = 0; csum_m = 0;
        for (int c = 1; c <= 100 && !seen; c++) begin
            if (out_valid && out_ready) begin
                if (nb < 32) begin
                    chk("full_addr", 32'(out_addr), 32'(nb));
                    chk("full_data", out_data, regval(nb));
                    chk("full_last", 32'(out_last), 32'((nb == 31) && (CS == 0)));
                    csum_m ^= regval(nb);
                end else begin
                    chk("csum_addr", 32'(out_addr), 0);
                    chk("csum_data", out_data, csum_m);
                    chk("csum_last", 32'(out_last), 1);
                end
                nb++;
            end
            step();
            if (done) begin
                seen = 1;
                chk("full_done_cycle", 32'(c), 32'(64 + CS));
                chk("full_done_busy", 32'(busy), 0);
            end
        end
        chk("full_done_seen", 32'(seen), 1);
        chk("full_beats", 32'(nb), 32'(32 + CS));
        step();
        chk("done_one_cycle", 32'(done), 0);

        // ---- backpressure on r7 ----
        start = 1; step(); start = 0;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (out_valid && out_addr == 5'd7) found = 1;
            else step();
        end
        chk("bp_found_r7", 32'(found), 1);
        out_ready = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_addr", 32'(out_addr), 7);
            chk("bp_data", out_data, regval(7));
            chk("bp_dbg_addr", 32'(debug_addr), 7);
        end
        out_ready = 1; step();
        chk("bp_after_valid", 32'(out_valid), 0);
        chk("bp_after_dbg", 32'(debug_addr), 8);
        abort = 1; step(); abort = 0;
        chk("bp_abort_busy", 32'(busy), 0);

        // ---- abort on r10 with out_ready high ----
        start = 1; step(); start = 0;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (out_valid && out_addr == 5'd10) found = 1;
            else step();
        end
        chk("ab_found_r10", 32'(found), 1);
        abort = 1; step(); abort = 0;
        chk("ab_valid", 32'(out_valid), 0);
        chk("ab_busy", 32'(busy), 0);
        any_done = done;
        for (int k = 0; k < 6; k++) begin
            step();
            any_done |= done;
        end
        chk("ab_no_done", 32'(any_done), 0);
        start = 1; step(); start = 0;
        chk("ab_restart_busy", 32'(busy), 1);
        chk("ab_restart_dbg", 32'(debug_addr), 0);
        step();
        chk("ab_restart_valid", 32'(out_valid), 1);
        chk("ab_restart_addr", 32'(out_addr), 0);
        chk("ab_restart_data", out_data, 0);
        abort = 1; step(); abort = 0;

        // ---- reset during r20 WAIT, with an ignored start while busy ----
        start = 1; step(); start = 0;
        found = 0;
        for (int c = 0; c < 80 && !found; c++) begin
            if (busy && !out_valid && debug_addr == 5'd20) found = 1;
            else begin
                start = (c == 5);
                step();
            end
        end
        start = 0;
        chk("rm_found_r20", 32'(found), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rm_dbg_addr", 32'(debug_addr), 0);
        chk("rm_valid", 32'(out_valid), 0);
        chk("rm_out_addr", 32'(out_addr), 0);
        chk("rm_out_data", out_data, 0);
        chk("rm_last", 32'(out_last), 0);
        chk("rm_busy", 32'(busy), 0);
        chk("rm_done", 32'(done), 0);
        step();
        rst_n = 1'b1;
        step(); step();
        chk("rm_no_replay_busy", 32'(busy), 0);
        chk("rm_no_replay_valid", 32'(out_valid), 0);

        // ---- subrange instance r8..r15 ----
        s_ready = 1;
        s_start = 1; step(); s_start = 0;
        nb = 0; seen = 0; csum_m = 0;
        for (int c = 1; c <= 60 && !seen; c++) begin
            if (s_out_valid && s_ready) begin
                if (nb < 8) begin
                    chk("sub_addr", 32'(s_out_addr), 32'(8 + nb));
                    chk("sub_data", s_out_data, regval(8 + nb));
                    chk("sub_last", 32'(s_out_last), 32'((nb == 7) && (CS == 0)));
                    csum_m ^= regval(8 + nb);
                end else begin
                    chk("sub_csum_addr", 32'(s_out_addr), 0);
                    chk("sub_csum_data", s_out_data, csum_m);
                    chk("sub_csum_last", 32'(s_out_last), 1);
                end
                nb++;
            end
            step();
            if (s_done) begin
                seen = 1;
                chk("sub_done_cycle", 32'(c), 32'(16 + CS));
            end
        end
        chk("sub_done_seen", 32'(seen), 1);
        chk("sub_beats", 32'(nb), 32'(8 + CS));
        // start in the done cycle is accepted
        s_start = 1; step(); s_start = 0;
        chk("sub_start_on_done", 32'(s_busy), 1);
        chk("sub_restart_dbg", 32'(s_debug_addr), 8);
        s_abort = 1; step(); s_abort = 0;
        chk("sub_abort_busy", 32'(s_busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
